// File: rtl/ws2812_frame_driver_if.sv
// Pixel-buffer read port between ws2812_frame_driver (master) and the buffer (slave).
// Read data is registered: rd_data is valid one clk after the rd_en cycle.
interface ws2812_frame_driver_if #(
    parameter int unsigned ADDR_W = 6
) ();
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/ws2812_frame_driver.sv
// Streams 3*NUM_LEDS buffer bytes MSB-first as WS2812 NRZ cells, then latches low and pulses done.
// Define WS2812_GRB_REMAP_EN to read an RGB buffer in G,R,B wire order.
module ws2812_frame_driver #(
    parameter int unsigned NUM_LEDS = 18,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned T0H      = 19,
    parameter int unsigned T1H      = 38,
    parameter int unsigned TBIT     = 60,
    parameter int unsigned TRESET   = 2880
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    ws2812_frame_driver_if.master        buf_if,
    output logic                         dout
);
    localparam int unsigned CW = $clog2(TBIT);
    localparam int unsigned RW = (TRESET > 1) ? $clog2(TRESET) : 1;
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(3 * NUM_LEDS - 1);
`ifdef WS2812_GRB_REMAP_EN
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_ADDR = '0;
`endif

    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_CAPTURE, ST_SEND, ST_LATCH} state_t;

    state_t            state_q, state_d;
    logic              dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        stage_q, stage_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [CW-1:0]     cell_cnt_q, cell_cnt_d;
    logic [ADDR_W-1:0] byte_idx_q, byte_idx_d;
    logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
`ifdef WS2812_GRB_REMAP_EN
    // led_base tracks 3*led incrementally; k is the byte slot within the LED
    logic [ADDR_W-1:0] led_base_q, led_base_d;
    logic [1:0]        k_q, k_d;
`endif

    function automatic logic [CW-1:0] high_len(input logic b);
        return b ? CW'(T1H) : CW'(T0H);
    endfunction

    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        shift_d    = shift_q;
        stage_d    = stage_q;
        bit_idx_d  = bit_idx_q;
        cell_cnt_d = cell_cnt_q;
        byte_idx_d = byte_idx_q;
        rst_cnt_d  = rst_cnt_q;
`ifdef WS2812_GRB_REMAP_EN
        led_base_d = led_base_q;
        k_d        = k_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    busy_d     = 1'b1;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = FIRST_ADDR;
                    byte_idx_d = '0;
`ifdef WS2812_GRB_REMAP_EN
                    led_base_d = '0;
                    k_d        = 2'd0;
`endif
                end
            end
            ST_FETCH: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                shift_d    = buf_if.rd_data;
                bit_idx_d  = 3'd7;
                cell_cnt_d = '0;
                dout_d     = (high_len(buf_if.rd_data[7]) != '0);
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (cell_cnt_q == CW'(TBIT - 1)) begin
                    cell_cnt_d = '0;
                    if (bit_idx_q != 3'd0) begin
                        bit_idx_d = bit_idx_q - 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        dout_d    = (high_len(shift_q[6]) != '0);
                        // Issue the prefetch so rd_en lands on cell_cnt 0 of the byte's last cell
                        if (bit_idx_q == 3'd1 && byte_idx_q != LAST_BYTE) begin
                            rd_en_d = 1'b1;
`ifdef WS2812_GRB_REMAP_EN
                            case (k_q)
                                2'd0: begin
                                    rd_addr_d = led_base_q;
                                    k_d       = 2'd1;
                                end
                                2'd1: begin
                                    rd_addr_d = led_base_q + ADDR_W'(2);
                                    k_d       = 2'd2;
                                end
                                default: begin
                                    rd_addr_d  = led_base_q + ADDR_W'(4);
                                    led_base_d = led_base_q + ADDR_W'(3);
                                    k_d        = 2'd0;
                                end
                            endcase
`else
                            rd_addr_d = rd_addr_q + ADDR_W'(1);
`endif
                        end
                    end else if (byte_idx_q != LAST_BYTE) begin
                        shift_d    = stage_q;
                        bit_idx_d  = 3'd7;
                        byte_idx_d = byte_idx_q + ADDR_W'(1);
                        dout_d     = (high_len(stage_q[7]) != '0);
                    end else begin
                        state_d   = ST_LATCH;
                        dout_d    = 1'b0;
                        rst_cnt_d = '0;
                    end
                end else begin
                    cell_cnt_d = cell_cnt_q + CW'(1);
                    dout_d     = ((cell_cnt_q + CW'(1)) < high_len(shift_q[7]));
                    if (bit_idx_q == 3'd0 && cell_cnt_q == CW'(1) && byte_idx_q != LAST_BYTE)
                        stage_d = buf_if.rd_data;
                end
            end
            ST_LATCH: begin
                dout_d = 1'b0;
                if (rst_cnt_q == RW'(TRESET - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dout_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            shift_q    <= '0;
            stage_q    <= '0;
            bit_idx_q  <= '0;
            cell_cnt_q <= '0;
            byte_idx_q <= '0;
            rst_cnt_q  <= '0;
`ifdef WS2812_GRB_REMAP_EN
            led_base_q <= '0;
            k_q        <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            shift_q    <= shift_d;
            stage_q    <= stage_d;
            bit_idx_q  <= bit_idx_d;
            cell_cnt_q <= cell_cnt_d;
            byte_idx_q <= byte_idx_d;
            rst_cnt_q  <= rst_cnt_d;
`ifdef WS2812_GRB_REMAP_EN
            led_base_q <= led_base_d;
            k_q        <= k_d;
`endif
        end
    end

    assign dout           = dout_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign buf_if.rd_en   = rd_en_q;
    assign buf_if.rd_addr = rd_addr_q;
endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Scoreboard bench for ws2812_frame_driver: expected wire bytes and read addresses are queued
// per frame and checked by a monitor decoding dout pulse widths and buffer reads.
module tb_ws2812_frame_driver;
    localparam int unsigned NUM_LEDS  = 2;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned T0H       = 2;
    localparam int unsigned T1H       = 4;
    localparam int unsigned TBIT      = 6;
    localparam int unsigned TRESET    = 10;
    localparam int unsigned NBYTES    = 3 * NUM_LEDS;
    localparam int unsigned FRAME_LEN = 2 + 24 * NUM_LEDS * TBIT + TRESET;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, dout;

    ws2812_frame_driver_if #(.ADDR_W(ADDR_W)) bus ();

    ws2812_frame_driver #(
        .NUM_LEDS(NUM_LEDS),
        .ADDR_W  (ADDR_W),
        .T0H     (T0H),
        .T1H     (T1H),
        .TBIT    (TBIT),
        .TRESET  (TRESET)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .buf_if(bus.master),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:7];
    int unsigned order [0:5];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  exp_bytes [$];
    int unsigned exp_addr [$];

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < NBYTES; i++) begin
            exp_addr.push_back(order[i]);
            exp_bytes.push_back(mem[order[i]]);
        end
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int unsigned done_cnt = 0;
    int          frame_start, busy_cnt, bits, last_rise, last_high, bitpos, w;
    int          bytes_in_frame, last_done, prev_done;
    logic        busy_p, dout_p;
    logic [7:0]  cur_exp, acc;

    initial begin
        busy_p = 0; dout_p = 0; bits = 0; bitpos = 0; bytes_in_frame = 0;
        frame_start = 0; busy_cnt = 0; last_rise = 0; last_high = 0;
        last_done = 0; prev_done = 0; cur_exp = '0; acc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_p = 0; dout_p = 0; bits = 0; bitpos = 0; bytes_in_frame = 0;
            end else begin
                if (bus.rd_en) begin
                    if (exp_addr.size() == 0) chk("reads_pending", exp_addr.size(), 1);
                    else chk("rd_addr", bus.rd_addr, exp_addr.pop_front());
                end
                if (busy && !busy_p) begin
                    frame_start = cyc; busy_cnt = 0; bits = 0; bitpos = 0; bytes_in_frame = 0;
                end
                if (busy) busy_cnt++;
                if (dout && !dout_p) begin
                    if (bits == 0) chk("first_rise", cyc - frame_start, 2);
                    else chk("cell_len", cyc - last_rise, TBIT);
                    last_rise = cyc;
                    bits++;
                    if (bitpos == 0) begin
                        if (exp_bytes.size() == 0) begin
                            chk("bytes_pending", exp_bytes.size(), 1);
                            cur_exp = '0;
                        end else begin
                            cur_exp = exp_bytes.pop_front();
                        end
                    end
                end
                if (!dout && dout_p) begin
                    w = cyc - last_rise;
                    chk("bit_width", w, cur_exp[7 - bitpos] ? T1H : T0H);
                    acc = {acc[6:0], (w > (T0H + T1H) / 2)};
                    bitpos++;
                    if (bitpos == 8) begin
                        chk("wire_byte", acc, cur_exp);
                        bitpos = 0;
                        bytes_in_frame++;
                    end
                end
                if (dout) last_high = cyc;
                if (done) begin
                    chk("frame_len", cyc - frame_start, FRAME_LEN);
                    chk("busy_len", busy_cnt, FRAME_LEN);
                    chk("latch_low", ((cyc - last_high) >= TRESET + 1), 1);
                    chk("bit_count", bits, 24 * NUM_LEDS);
                    prev_done = last_done;
                    last_done = cyc;
                    done_cnt++;
                end
                busy_p = busy;
                dout_p = dout;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned n0);
        int t = 0;
        while (done_cnt == n0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt == n0) chk("done_timeout", done_cnt, n0 + 1);
    endtask

    task automatic chk_drained();
        chk("sb_bytes_left", exp_bytes.size(), 0);
        chk("sb_addr_left", exp_addr.size(), 0);
    endtask

    initial begin
        int unsigned bad, n0, t;
`ifdef WS2812_GRB_REMAP_EN
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
        order = '{1, 0, 2, 4, 3, 5};
`else
        mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'hFF;
        mem[3] = 8'h01; mem[4] = 8'h80; mem[5] = 8'h3C;
        order = '{0, 1, 2, 3, 4, 5};
`endif
        mem[6] = 8'hEE; mem[7] = 8'hEE;

        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        rst_n = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (dout || busy || done || bus.rd_en) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Single frame
        push_frame();
        n0 = done_cnt;
        pulse_start();
        wait_done(n0);
        chk_drained();

        // Extra start pulses while busy are ignored
        repeat (5) @(negedge clk);
        push_frame();
        n0 = done_cnt;
        pulse_start();
        repeat (48) @(negedge clk);
        pulse_start();
        repeat (99) @(negedge clk);
        pulse_start();
        wait_done(n0);
        chk_drained();

        // start held high: back-to-back frames
        repeat (5) @(negedge clk);
        push_frame();
        push_frame();
        n0 = done_cnt;
        start = 1'b1;
        wait_done(n0);
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_done(n0 + 1);
        chk("b2b_period", last_done - prev_done, FRAME_LEN + 1);
        chk_drained();

        // Asynchronous reset during byte 3
        repeat (5) @(negedge clk);
        push_frame();
        pulse_start();
        t = 0;
        while (bytes_in_frame < 3 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("reached_byte3", bytes_in_frame, 3);
        t = 0;
        while (!dout && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("byte3_high", dout, 1);
        #1 rst_n = 1'b0;
        #1 chk("async_dout", dout, 0);
        chk("async_busy", busy, 0);
        exp_bytes.delete();
        exp_addr.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push_frame();
        n0 = done_cnt;
        pulse_start();
        wait_done(n0);
        chk_drained();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ws2812_frame_driver.md
Name: ws2812_frame_driver

Overview:
- Downstream consumer of the SPI receive path. The SPI stage assembles bytes from the MCU and writes them into the pixel buffer (SPRAM/EBR); this block reads that buffer and drives the WS2812 LED string data line.
- On `start` it streams 3*NUM_LEDS bytes, MSB first, as WS2812 NRZ bit cells. It then holds the line low for the latch/reset period and pulses `done`.
- Default frame is 18 LEDs × 24 bits = 432 bits.

Parameters:
- NUM_LEDS, 18, number of LEDs in the string (3 bytes each)
- ADDR_W, 6, buffer address width; must satisfy 2**ADDR_W >= 3*NUM_LEDS
- T0H, 19, clk cycles dout is high for a '0' bit (0.4 us @ 48 MHz)
- T1H, 38, clk cycles dout is high for a '1' bit (0.8 us @ 48 MHz)
- TBIT, 60, total clk cycles per bit cell (1.25 us @ 48 MHz); requires T0H < T1H < TBIT, T1H >= 2
- TRESET, 2880, clk cycles dout is held low after the last bit (60 us @ 48 MHz)

Ports:
- clk  input  1  system clock (48 MHz HSOSC)
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to send one frame; sampled only in IDLE
- busy  output  1  high from frame acceptance until the cycle `done` pulses
- done  output  1  one-cycle pulse when the latch period ends
- rd_en  output  1  pixel-buffer read strobe
- rd_addr  output  ADDR_W  pixel-buffer byte address
- rd_data  input  8  buffer data, valid exactly 1 clk after the rd_en cycle (registered read)
- dout  output  1  WS2812 serial data line

Behaviour:
- Reset values (asynchronous): state=IDLE, dout=0, busy=0, done=0, rd_en=0, rd_addr=0, all counters=0. Asserting reset mid-frame drops dout low immediately; the next frame starts from byte 0.
- States: IDLE, FETCH, CAPTURE, SEND, LATCH.
- IDLE→FETCH: on start=1. Same edge sets busy=1.
- FETCH (1 cycle): rd_en=1, rd_addr=0.
- CAPTURE (1 cycle): latch rd_data into the shift register; bit_idx=7, cell_cnt=0.
- SEND: one bit cell = TBIT cycles.
  - cell_cnt counts 0..TBIT-1.
  - dout=1 while cell_cnt < (bit ? T1H : T0H), else 0. dout is registered.
  - First rising edge of dout is in the 3rd cycle after start is sampled.
- Prefetch: during the cell for bit_idx=0, if byte_idx < 3*NUM_LEDS-1:
  - rd_en pulses for one cycle at cell_cnt==0 with rd_addr = next address; data is captured into a staging register at cell_cnt==1.
  - At cell end the staging byte moves into the shift register, bit_idx=7, byte_idx+1.
  - Bit cells are contiguous: no gap cycles between bytes.
- Last bit of last byte: at cell end go to LATCH with dout=0.
- LATCH: count TRESET cycles with dout=0. On the final cycle go to IDLE and pulse done=1 for one cycle; busy falls on the same edge done rises.
- start while busy: ignored (no queueing). start held high through the done cycle: a new frame begins on the cycle after return to IDLE.
- Total frame length from start sample to done: 2 + 24*NUM_LEDS*TBIT + TRESET cycles.
- rd_addr is held at the last issued address when rd_en=0. rd_en is never asserted outside FETCH or a prefetch cycle.
- Buffer contents may change during SEND; bytes are read in time order, so no coherency guarantee is made.

Optional Feature:
- Macro: WS2812_GRB_REMAP_EN.
- Defined: the buffer holds RGB per LED (offsets 0,1,2). Per LED, bytes are read in offset order 1,0,2, so the wire sends G,R,B. Address = 3*led + {1,0,2}[k]; led and k are kept as separate counters, with no multiplier.
- Not defined: addresses are read sequentially 0..3*NUM_LEDS-1, and the buffer must already be in GRB order.
- Frame timing is identical in both builds.

Test Plan (NUM_LEDS=2, T0H=2, T1H=4, TBIT=6, TRESET=10, macro off unless noted):
- Reset release, no start: dout=0, busy=0, done=0, rd_en=0 for 100 cycles.
- Buffer bytes {A5,00,FF,01,80,3C}, start pulse → dout high widths 4,2,4,2,2,4,2,4 for byte 0. Every cell is exactly 6 cycles, and there is no gap across all 48 cells. rd_addr sequence is 0..5.
- Same frame, timing: done pulses exactly 2+48*6+10=300 cycles after start is sampled; busy is high for 300 cycles; dout=0 throughout the final 10 cycles.
- start pulsed again at cycles 50 and 150 of a frame → no extra reads and frame length unchanged. start held high continuously → back-to-back frames 301 cycles apart.
- rst_n asserted during byte 3 → dout drops to 0 asynchronously. The next start reads address 0 first.
- WS2812_GRB_REMAP_EN defined, buffer {11,22,33,44,55,66} → wire byte order 22,11,33,55,44,66; rd_addr sequence 1,0,2,4,3,5.
